// File: rtl/cla_addsub_pipe_pkg.sv
// Shared ALU constants: flag bit positions in out_flags and the add/sub op encoding.
package cla_addsub_pipe_pkg;

  localparam int unsigned NUM_FLAGS = 4;
  localparam int unsigned FLAG_C    = 3;
  localparam int unsigned FLAG_V    = 2;
  localparam int unsigned FLAG_Z    = 1;
  localparam int unsigned FLAG_N    = 0;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_op_e;

endpackage

// File: rtl/cla_addsub_pipe_if.sv
// Operand/result handshake bundle for cla_addsub_pipe; master drives operands, slave is the adder.
interface cla_addsub_pipe_if
  import cla_addsub_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 in_sub;
  logic                 in_cin;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_res;
  logic [NUM_FLAGS-1:0] out_flags;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    input  in_ready, out_valid, out_res, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    output in_ready, out_valid, out_res, out_flags
  );
endinterface

// File: rtl/cla_addsub_pipe_cla_group.sv
// Combinational GROUP-bit carry-look-ahead block: sum, carry-out, group P/G and carry into the MSB.
module cla_group #(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] a_i,
  input  logic [GROUP-1:0] b_i,
  input  logic             cin_i,
  output logic [GROUP-1:0] sum_o,
  output logic             cout_o,
  output logic             p_o,
  output logic             g_o,
  output logic             cmsb_o
);
  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;
  logic             pacc;
  logic             gacc;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  // Each carry is a flat sum of products over the lower bits, not a ripple.
  always_comb begin
    c    = '0;
    pacc = 1'b0;
    c[0] = cin_i;
    for (int unsigned i = 0; i < GROUP; i++) begin
      c[i+1] = g[i];
      pacc   = p[i];
      for (int unsigned j = i; j > 0; j--) begin
        c[i+1] = c[i+1] | (g[j-1] & pacc);
        pacc   = pacc & p[j-1];
      end
      c[i+1] = c[i+1] | (cin_i & pacc);
    end
  end

  always_comb begin
    gacc = 1'b0;
    for (int unsigned i = 0; i < GROUP; i++) begin
      gacc = g[i] | (p[i] & gacc);
    end
  end

  assign sum_o  = p ^ c[GROUP-1:0];
  assign cout_o = c[GROUP];
  assign cmsb_o = c[GROUP-1];
  assign p_o    = &p;
  assign g_o    = gacc;
endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined CLA adder/subtractor with valid/ready on both sides and {C,V,Z,N} flags.
// Define CLA_ADDSUB_SATURATE_EN to clamp overflowing results to the signed max/min.
module cla_addsub_pipe
  import cla_addsub_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned GROUP  = 4,
  parameter int unsigned STAGES = 2
) (
  input logic               clk,
  input logic               rst,
  cla_addsub_pipe_if.slave  bus
);
  localparam int unsigned NGRP = WIDTH / GROUP;
  localparam int unsigned GPS  = NGRP / STAGES;
  localparam int unsigned MID  = (STAGES > 1) ? STAGES - 1 : 1;

  function automatic logic [WIDTH-1:0] stage_mask(input int unsigned s);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int unsigned i = s * GPS * GROUP; i < (s + 1) * GPS * GROUP; i++) m[i] = 1'b1;
    return m;
  endfunction

  addsub_op_e           op;
  logic [STAGES-1:0]    adv;
  logic [STAGES-1:0]    valid_q;
  logic [WIDTH-1:0]     st_a    [STAGES];
  logic [WIDTH-1:0]     st_b    [STAGES];
  logic [WIDTH-1:0]     st_res  [STAGES];
  logic [WIDTH-1:0]     st_resn [STAGES];
  logic                 st_cin  [STAGES];
  logic [WIDTH-1:0]     mid_a_q   [MID];
  logic [WIDTH-1:0]     mid_b_q   [MID];
  logic [WIDTH-1:0]     mid_res_q [MID];
  logic [MID-1:0]       mid_cy_q;
  logic [WIDTH-1:0]     sum_all;
  logic [NGRP-1:0]      gcout, gcmsb, gp, gg;
  logic [WIDTH-1:0]     res_d, res_q;
  logic [NUM_FLAGS-1:0] flags_d, flags_q;
  logic                 c_flag, v_flag;
  logic                 unused_grp;

  assign op = addsub_op_e'(bus.in_sub);

  // A stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    adv           = '0;
    adv[STAGES-1] = ~valid_q[STAGES-1] | bus.out_ready;
    for (int unsigned s = STAGES - 1; s > 0; s--) adv[s-1] = ~valid_q[s-1] | adv[s];
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.out_res   = res_q;
  assign bus.out_flags = flags_q;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    if (s == 0) begin : g_first
      assign st_a[0]   = bus.in_a;
      assign st_b[0]   = (op == OP_SUB) ? ~bus.in_b : bus.in_b;
      assign st_cin[0] = (op == OP_SUB) ? 1'b1 : bus.in_cin;
      assign st_res[0] = '0;
    end else begin : g_later
      assign st_a[s]   = mid_a_q[s-1];
      assign st_b[s]   = mid_b_q[s-1];
      assign st_cin[s] = mid_cy_q[s-1];
      assign st_res[s] = mid_res_q[s-1];
    end
    assign st_resn[s] = (st_res[s] & ~stage_mask(s)) | (sum_all & stage_mask(s));
  end

  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    localparam int unsigned S = k / GPS;
    logic gcin;
    if ((k % GPS) == 0) begin : g_head
      assign gcin = st_cin[S];
    end else begin : g_chain
      assign gcin = gcout[k-1];
    end
    cla_group #(.GROUP(GROUP)) u_grp (
      .a_i    (st_a[S][k*GROUP +: GROUP]),
      .b_i    (st_b[S][k*GROUP +: GROUP]),
      .cin_i  (gcin),
      .sum_o  (sum_all[k*GROUP +: GROUP]),
      .cout_o (gcout[k]),
      .p_o    (gp[k]),
      .g_o    (gg[k]),
      .cmsb_o (gcmsb[k])
    );
  end

  assign unused_grp = ^{gp, gg, gcmsb};

  always_comb begin
    c_flag = gcout[NGRP-1];
    v_flag = gcmsb[NGRP-1] ^ gcout[NGRP-1];
    res_d  = st_resn[STAGES-1];
`ifdef CLA_ADDSUB_SATURATE_EN
    if (v_flag) begin
      res_d = st_a[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    flags_d         = '0;
    flags_d[FLAG_C] = c_flag;
    flags_d[FLAG_V] = v_flag;
    flags_d[FLAG_Z] = (res_d == '0);
    flags_d[FLAG_N] = res_d[WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      res_q    <= '0;
      flags_q  <= '0;
      mid_cy_q <= '0;
      for (int unsigned s = 0; s < MID; s++) begin
        mid_a_q[s]   <= '0;
        mid_b_q[s]   <= '0;
        mid_res_q[s] <= '0;
      end
    end else begin
      if (adv[0]) valid_q[0] <= bus.in_valid;
      for (int unsigned s = 1; s < STAGES; s++) begin
        if (adv[s]) valid_q[s] <= valid_q[s-1];
      end
      // Data only loads behind a valid beat so results hold across bubbles.
      for (int unsigned s = 0; s + 1 < STAGES; s++) begin
        if (adv[s] && ((s == 0) ? bus.in_valid : valid_q[s-1])) begin
          mid_a_q[s]   <= st_a[s];
          mid_b_q[s]   <= st_b[s];
          mid_res_q[s] <= st_resn[s];
          mid_cy_q[s]  <= gcout[(s+1)*GPS-1];
        end
      end
      if (adv[STAGES-1] && ((STAGES == 1) ? bus.in_valid : valid_q[STAGES-2])) begin
        res_q   <= res_d;
        flags_q <= flags_d;
      end
    end
  end
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Directed bench for cla_addsub_pipe (WIDTH=8, GROUP=4, STAGES=2); honours CLA_ADDSUB_SATURATE_EN.
module tb_cla_addsub_pipe;
  import cla_addsub_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cla_addsub_pipe_if #(.WIDTH(8)) bus ();

  cla_addsub_pipe #(.WIDTH(8), .GROUP(4), .STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef CLA_ADDSUB_SATURATE_EN
  localparam logic [7:0] E1_RES = 8'h7F;
  localparam logic [3:0] E1_FL  = 4'b0100;
  localparam logic [7:0] E5_RES = 8'h80;
  localparam logic [3:0] E5_FL  = 4'b1101;
`else
  localparam logic [7:0] E1_RES = 8'h80;
  localparam logic [3:0] E1_FL  = 4'b0101;
  localparam logic [7:0] E5_RES = 8'h7F;
  localparam logic [3:0] E5_FL  = 4'b1100;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic c);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sub   = s;
    bus.in_cin   = c;
  endtask

  // Reference: {res, C, V, Z, N} from a plain 9-bit sum and sign-rule overflow.
  function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic s, input logic c);
    logic [7:0] bb;
    logic [8:0] sum;
    logic [7:0] r;
    logic       v;
    bb  = s ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {8'b0, (s ? 1'b1 : c)};
    r   = sum[7:0];
    v   = (a[7] == bb[7]) && (r[7] != a[7]);
`ifdef CLA_ADDSUB_SATURATE_EN
    if (v) r = a[7] ? 8'h80 : 8'h7F;
`endif
    return {r, sum[8], v, (r == 8'h00), r[7]};
  endfunction

  function automatic logic [15:0] outv();
    return 16'({bus.out_valid, bus.out_res, bus.out_flags});
  endfunction

  task automatic beat(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic s, input logic c, input logic [7:0] er, input logic [3:0] ef);
    drive(1'b1, a, b, s, c);
    bus.out_ready = 1'b1;
    chk({tag, "_rdy"}, 16'(bus.in_ready), 16'(1));
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    chk({tag, "_lat1"}, 16'(bus.out_valid), 16'(0));
    tick();
    chk({tag, "_out"}, outv(), 16'({1'b1, er, ef}));
    tick();
  endtask

  logic [7:0] ra [16];
  logic [7:0] rb [16];
  logic       rs [16];
  logic       rc [16];

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    repeat (2) tick();
    chk("reset_out", outv(), 16'(0));
    chk("reset_in_ready", 16'(bus.in_ready), 16'(1));
    rst = 1'b0;
    tick();

    beat("add_7f_01",   8'h7F, 8'h01, 1'b0, 1'b0, E1_RES, E1_FL);
    beat("add_ff_01",   8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 4'b1010);
    beat("add_0f_cin",  8'h0F, 8'h00, 1'b0, 1'b1, 8'h10, 4'b0000);
    beat("sub_05_07",   8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 4'b0001);
    beat("sub_80_01",   8'h80, 8'h01, 1'b1, 1'b0, E5_RES, E5_FL);

    // Back-to-back beats, one result per clock.
    for (int i = 0; i < 16; i++) begin
      ra[i] = 8'($urandom_range(0, 255));
      rb[i] = 8'($urandom_range(0, 255));
      rs[i] = 1'($urandom_range(0, 1));
      rc[i] = 1'($urandom_range(0, 1));
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 17; c++) begin
      if (c < 16) begin
        drive(1'b1, ra[c], rb[c], rs[c], rc[c]);
        chk("b2b_rdy", 16'(bus.in_ready), 16'(1));
      end else begin
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      end
      tick();
      if (c >= 1) chk("b2b_out", outv(), 16'({1'b1, model(ra[c-1], rb[c-1], rs[c-1], rc[c-1])}));
    end
    tick();
    chk("b2b_drained", 16'(bus.out_valid), 16'(0));

    // Backpressure: two beats fill the pipe, the third waits.
    bus.out_ready = 1'b0;
    drive(1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
    chk("bp_rdy1", 16'(bus.in_ready), 16'(1));
    tick();
    drive(1'b1, 8'h30, 8'h10, 1'b1, 1'b0);
    chk("bp_rdy2", 16'(bus.in_ready), 16'(1));
    tick();
    drive(1'b1, 8'h80, 8'h80, 1'b0, 1'b0);
    chk("bp_rdy3_blocked", 16'(bus.in_ready), 16'(0));
    tick();
    chk("bp_stall_hold", outv(), 16'({1'b1, 8'h30, 4'b0000}));
    chk("bp_rdy3_still", 16'(bus.in_ready), 16'(0));
    bus.out_ready = 1'b1;
    #1;
    chk("bp_rdy_comb", 16'(bus.in_ready), 16'(1));
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("bp_out2", outv(), 16'({1'b1, 8'h20, 4'b1000}));
    tick();
    chk("bp_out3", outv(), 16'({1'b1, model(8'h80, 8'h80, 1'b0, 1'b0)}));
    tick();
    chk("bp_empty", 16'(bus.out_valid), 16'(0));

    // Reset with two beats in flight drops them.
    drive(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h33, 8'h44, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_async_out", outv(), 16'(0));
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_stale", 16'(bus.out_valid), 16'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
